// File: rtl/gesture_command_gen.sv
// Converts per-frame hand coordinates into drone hover/roll/pitch bytes and an
// armed flag that a left-to-right swipe through the bottom dead zone toggles.
module gesture_command_gen #(
    parameter logic [15:0] DEAD_Y          = 16'd342,
    parameter logic [15:0] ZONE_W          = 16'd130,
    parameter logic [7:0]  HOVER_K         = 8'd191,
    parameter logic [15:0] MIN_Z_DEAD_ZONE = 16'd800,
    parameter logic [15:0] MAX_Z_DEAD_ZONE = 16'd1050,
    parameter logic [4:0]  TIMEOUT_FRAMES  = 5'd15
) (
    input  logic        vclock,
    input  logic        reset,
    input  logic        hands_valid,
    input  logic [15:0] x1,
    input  logic [15:0] y1,
    input  logic [15:0] z1,
    input  logic [15:0] x2,
    input  logic [15:0] y2,
    input  logic [15:0] z2,
    output logic [7:0]  hover,
    output logic [7:0]  roll,
    output logic [7:0]  pitch,
    output logic        on,
    output logic        cmd_valid,
    output logic [2:0]  swipe_state
);

    typedef enum logic [2:0] {IDLE, Z0, Z1, Z2, Z3, LOCK} state_e;

    state_e      state;
    logic [4:0]  cnt;

    logic        s1_valid;
    logic [16:0] s1_y_avg;
    logic [16:0] s1_dy;
    logic [15:0] s1_z_avg;
    logic [2:0]  s1_zone;
    logic        s1_tracked;
    logic        s1_in_dz;
    logic        s1_any_dz;

    logic [16:0] y_sum;
    logic [16:0] z_sum;
    logic [2:0]  zone;

    // The left-hand x coordinate plays no part in any command.
    logic unused_x1;
    assign unused_x1 = ^x1;

    assign y_sum = {1'b0, y1} + {1'b0, y2};
    assign z_sum = {1'b0, z1} + {1'b0, z2};

    always_comb begin
        zone = 3'd4;
        if (x2 < ZONE_W)
            zone = 3'd0;
        else if (x2 < 16'(ZONE_W * 16'd2))
            zone = 3'd1;
        else if (x2 < 16'(ZONE_W * 16'd3))
            zone = 3'd2;
        else if (x2 < 16'(ZONE_W * 16'd4))
            zone = 3'd3;
    end

    always_ff @(posedge vclock) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= hands_valid;
        end
        if (hands_valid) begin
            s1_y_avg   <= {1'b0, y_sum[16:1]};
            s1_dy      <= {1'b0, y1} - {1'b0, y2};
            s1_z_avg   <= z_sum[16:1];
            s1_zone    <= zone;
            s1_tracked <= (z1 != 16'd0) && (z2 != 16'd0);
            s1_in_dz   <= (y2 >= DEAD_Y);
            s1_any_dz  <= (y1 >= DEAD_Y) || (y2 >= DEAD_Y);
        end
    end

    // The toggle is visible combinationally so stage 2 sees this frame's armed state.
    logic toggle;
    logic on_next;
    assign toggle  = s1_valid && s1_tracked && s1_in_dz && (state == Z3) && (s1_zone == 3'd4);
    assign on_next = on ^ toggle;
    assign swipe_state = state;

    always_ff @(posedge vclock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 5'd0;
            on    <= 1'b0;
        end else if (s1_valid) begin
            on <= on_next;
            if (!s1_tracked || !s1_in_dz) begin
                state <= IDLE;
                cnt   <= 5'd0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt <= 5'd0;
                        if (s1_zone == 3'd0)
                            state <= Z0;
                    end
                    LOCK: cnt <= 5'd0;
                    default: begin
                        if (s1_zone == 3'(state)) begin
                            state <= (state == Z3) ? LOCK : state_e'(state + 3'd1);
                            cnt   <= 5'd0;
                        end else if (s1_zone == 3'(state - 3'd1)) begin
                            if (cnt + 5'd1 == TIMEOUT_FRAMES) begin
                                state <= IDLE;
                                cnt   <= 5'd0;
                            end else begin
                                cnt <= cnt + 5'd1;
                            end
                        end else begin
                            state <= (s1_zone == 3'd0) ? Z0 : IDLE;
                            cnt   <= 5'd0;
                        end
                    end
                endcase
            end
        end
    end

    function automatic logic [7:0] sat8(input logic signed [31:0] v);
        if (v < 0)
            return 8'd0;
        else if (v > 32'sd255)
            return 8'd255;
        else
            return v[7:0];
    endfunction

    logic signed [31:0] h_diff, h_val, dy_ext, r_val, z_ext, p_val;

    always_comb begin
        h_diff = $signed({16'd0, DEAD_Y}) - 32'sd1 - $signed({15'd0, s1_y_avg});
        h_val  = (h_diff * $signed({24'd0, HOVER_K})) >>> 8;
        dy_ext = $signed({{15{s1_dy[16]}}, s1_dy});
        r_val  = 32'sd128 + (dy_ext >>> 1);
        z_ext  = $signed({16'd0, s1_z_avg});
        p_val  = 32'sd128;
        if (z_ext < $signed({16'd0, MIN_Z_DEAD_ZONE}))
            p_val = 32'sd128 - (($signed({16'd0, MIN_Z_DEAD_ZONE}) - z_ext) >>> 2);
        else if (z_ext >= $signed({16'd0, MAX_Z_DEAD_ZONE}))
            p_val = 32'sd128 + ((z_ext - $signed({16'd0, MAX_Z_DEAD_ZONE})) >>> 2);
    end

    always_ff @(posedge vclock) begin
        if (reset) begin
            cmd_valid <= 1'b0;
            hover     <= 8'd0;
            roll      <= 8'd128;
            pitch     <= 8'd128;
        end else begin
            cmd_valid <= s1_valid;
            if (s1_valid) begin
                if (!on_next || !s1_tracked || s1_any_dz) begin
                    hover <= 8'd0;
                    roll  <= 8'd128;
                    pitch <= 8'd128;
                end else begin
                    hover <= sat8(h_val);
                    roll  <= sat8(r_val);
                    pitch <= sat8(p_val);
                end
            end
        end
    end

endmodule

// File: tb/tb_gesture_command_gen.sv
// Directed bench for gesture_command_gen: swipe arming, command math,
// saturation, swipe timeout, pipeline throughput and reset flushing.
module tb_gesture_command_gen;

    localparam logic [2:0] S_IDLE = 3'd0, S_Z0 = 3'd1, S_Z1 = 3'd2,
                           S_Z2 = 3'd3, S_Z3 = 3'd4, S_LOCK = 3'd5;

    logic        vclock = 1'b0;
    logic        reset;
    logic        hands_valid;
    logic [15:0] x1, y1, z1, x2, y2, z2;
    logic [7:0]  hover, roll, pitch;
    logic        on, cmd_valid;
    logic [2:0]  swipe_state;

    int errors = 0;
    int checks = 0;

    gesture_command_gen dut (
        .vclock(vclock), .reset(reset), .hands_valid(hands_valid),
        .x1(x1), .y1(y1), .z1(z1), .x2(x2), .y2(y2), .z2(z2),
        .hover(hover), .roll(roll), .pitch(pitch), .on(on),
        .cmd_valid(cmd_valid), .swipe_state(swipe_state)
    );

    always #5 vclock = ~vclock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] x2v, y1v, y2v, z1v, z2v);
        x1 = 16'($urandom_range(0, 639));
        x2 = x2v; y1 = y1v; y2 = y2v; z1 = z1v; z2 = z2v;
        hands_valid = 1'b1;
    endtask

    // Inputs are scrambled after the strobe so only the strobe-cycle values matter.
    task automatic scramble();
        x1 = 16'($urandom_range(0, 65535)); x2 = 16'($urandom_range(0, 65535));
        y1 = 16'($urandom_range(0, 65535)); y2 = 16'($urandom_range(0, 65535));
        z1 = 16'($urandom_range(0, 65535)); z2 = 16'($urandom_range(0, 65535));
    endtask

    task automatic send(input logic [15:0] x2v, y1v, y2v, z1v, z2v);
        @(negedge vclock);
        drive(x2v, y1v, y2v, z1v, z2v);
        @(negedge vclock);
        hands_valid = 1'b0;
        scramble();
        chk("latency_n1", 32'(cmd_valid), 32'd0);
        @(negedge vclock);
        chk("latency_n2", 32'(cmd_valid), 32'd1);
    endtask

    task automatic expect_out(input string tag, input logic [7:0] h, r, p,
                              input logic o, input logic [2:0] st);
        chk({tag, "_hover"}, 32'(hover), 32'(h));
        chk({tag, "_roll"},  32'(roll),  32'(r));
        chk({tag, "_pitch"}, 32'(pitch), 32'(p));
        chk({tag, "_on"},    32'(on),    32'(o));
        chk({tag, "_state"}, 32'(swipe_state), 32'(st));
    endtask

    initial begin
        reset = 1'b1;
        hands_valid = 1'b0;
        x1 = 0; x2 = 0; y1 = 0; y2 = 0; z1 = 0; z2 = 0;

        // Reset held two cycles with strobes pulsing.
        @(negedge vclock);
        drive(16'd300, 16'd100, 16'd100, 16'd900, 16'd900);
        @(negedge vclock);
        chk("rst_cmd_valid_a", 32'(cmd_valid), 32'd0);
        expect_out("rst", 8'd0, 8'd128, 8'd128, 1'b0, S_IDLE);
        @(negedge vclock);
        chk("rst_cmd_valid_b", 32'(cmd_valid), 32'd0);
        reset = 1'b0;
        hands_valid = 1'b0;
        @(negedge vclock);
        chk("post_rst_a", 32'(cmd_valid), 32'd0);
        @(negedge vclock);
        chk("post_rst_b", 32'(cmd_valid), 32'd0);

        // Arm swipe; dead-zone frames always give neutral outputs.
        send(16'd50,  16'd100, 16'd400, 16'd900, 16'd900);
        expect_out("arm1", 8'd0, 8'd128, 8'd128, 1'b0, S_Z0);
        send(16'd200, 16'd100, 16'd400, 16'd900, 16'd900);
        expect_out("arm2", 8'd0, 8'd128, 8'd128, 1'b0, S_Z1);
        send(16'd300, 16'd100, 16'd400, 16'd900, 16'd900);
        expect_out("arm3", 8'd0, 8'd128, 8'd128, 1'b0, S_Z2);
        send(16'd450, 16'd100, 16'd400, 16'd900, 16'd900);
        expect_out("arm4", 8'd0, 8'd128, 8'd128, 1'b0, S_Z3);
        send(16'd600, 16'd100, 16'd400, 16'd900, 16'd900);
        expect_out("arm5", 8'd0, 8'd128, 8'd128, 1'b1, S_LOCK);
        send(16'd600, 16'd100, 16'd400, 16'd900, 16'd900);
        expect_out("lock", 8'd0, 8'd128, 8'd128, 1'b1, S_LOCK);

        // Commands with on=1.
        send(16'd300, 16'd100, 16'd100, 16'd900, 16'd900);
        expect_out("cmd_a", 8'd179, 8'd128, 8'd128, 1'b1, S_IDLE);
        send(16'd300, 16'd200, 16'd100, 16'd700, 16'd700);
        expect_out("cmd_b", 8'd142, 8'd178, 8'd103, 1'b1, S_IDLE);
        send(16'd300, 16'd0, 16'd300, 16'd900, 16'd900);
        expect_out("roll_sat", 8'd142, 8'd0, 8'd128, 1'b1, S_IDLE);
        send(16'd300, 16'd100, 16'd100, 16'd2000, 16'd2000);
        expect_out("pitch_sat", 8'd179, 8'd128, 8'd255, 1'b1, S_IDLE);
        send(16'd300, 16'd100, 16'd100, 16'd796, 16'd796);
        expect_out("pitch_lo_edge", 8'd179, 8'd128, 8'd127, 1'b1, S_IDLE);
        send(16'd300, 16'd100, 16'd100, 16'd799, 16'd799);
        expect_out("pitch_band_lo", 8'd179, 8'd128, 8'd128, 1'b1, S_IDLE);
        send(16'd300, 16'd100, 16'd100, 16'd1053, 16'd1055);
        expect_out("pitch_hi_edge", 8'd179, 8'd128, 8'd129, 1'b1, S_IDLE);
        send(16'd300, 16'd341, 16'd341, 16'd900, 16'd900);
        expect_out("dead_y_edge", 8'd0, 8'd128, 8'd128, 1'b1, S_IDLE);
        send(16'd300, 16'd342, 16'd100, 16'd900, 16'd900);
        expect_out("left_in_dz", 8'd0, 8'd128, 8'd128, 1'b1, S_IDLE);

        // Untracked hand: neutral and FSM dropped back to IDLE.
        send(16'd50, 16'd100, 16'd400, 16'd900, 16'd900);
        expect_out("pre_untrack", 8'd0, 8'd128, 8'd128, 1'b1, S_Z0);
        send(16'd50, 16'd100, 16'd400, 16'd0, 16'd900);
        expect_out("untracked", 8'd0, 8'd128, 8'd128, 1'b1, S_IDLE);

        // Three back-to-back strobes.
        @(negedge vclock);
        drive(16'd300, 16'd100, 16'd100, 16'd900, 16'd900);
        @(negedge vclock);
        chk("pipe_n1", 32'(cmd_valid), 32'd0);
        drive(16'd300, 16'd200, 16'd100, 16'd700, 16'd700);
        @(negedge vclock);
        chk("pipe_cv_a", 32'(cmd_valid), 32'd1);
        expect_out("pipe_a", 8'd179, 8'd128, 8'd128, 1'b1, S_IDLE);
        drive(16'd300, 16'd0, 16'd300, 16'd2000, 16'd2000);
        @(negedge vclock);
        hands_valid = 1'b0;
        chk("pipe_cv_b", 32'(cmd_valid), 32'd1);
        expect_out("pipe_b", 8'd142, 8'd178, 8'd103, 1'b1, S_IDLE);
        @(negedge vclock);
        chk("pipe_cv_c", 32'(cmd_valid), 32'd1);
        expect_out("pipe_c", 8'd142, 8'd0, 8'd255, 1'b1, S_IDLE);
        @(negedge vclock);
        chk("pipe_done", 32'(cmd_valid), 32'd0);
        chk("pipe_hold_roll", 32'(roll), 32'd0);

        // Disarm swipe.
        send(16'd50,  16'd100, 16'd400, 16'd900, 16'd900);
        send(16'd200, 16'd100, 16'd400, 16'd900, 16'd900);
        send(16'd300, 16'd100, 16'd400, 16'd900, 16'd900);
        send(16'd450, 16'd100, 16'd400, 16'd900, 16'd900);
        expect_out("disarm4", 8'd0, 8'd128, 8'd128, 1'b1, S_Z3);
        send(16'd600, 16'd100, 16'd400, 16'd900, 16'd900);
        expect_out("disarm5", 8'd0, 8'd128, 8'd128, 1'b0, S_LOCK);
        send(16'd300, 16'd100, 16'd100, 16'd900, 16'd900);
        expect_out("disarmed", 8'd0, 8'd128, 8'd128, 1'b0, S_IDLE);

        // Timeout: 15 repeated frames in Z2 return to IDLE.
        send(16'd50,  16'd100, 16'd400, 16'd900, 16'd900);
        send(16'd200, 16'd100, 16'd400, 16'd900, 16'd900);
        send(16'd300, 16'd100, 16'd400, 16'd900, 16'd900);
        expect_out("to_z2", 8'd0, 8'd128, 8'd128, 1'b0, S_Z2);
        for (int i = 0; i < 14; i++)
            send(16'd300, 16'd100, 16'd400, 16'd900, 16'd900);
        chk("to_14_state", 32'(swipe_state), 32'(S_Z2));
        send(16'd300, 16'd100, 16'd400, 16'd900, 16'd900);
        chk("to_15_state", 32'(swipe_state), 32'(S_IDLE));
        send(16'd300, 16'd100, 16'd400, 16'd900, 16'd900);
        send(16'd450, 16'd100, 16'd400, 16'd900, 16'd900);
        send(16'd600, 16'd100, 16'd400, 16'd900, 16'd900);
        expect_out("to_no_toggle", 8'd0, 8'd128, 8'd128, 1'b0, S_IDLE);

        // Skipping a zone restarts; then arm at exact zone boundaries.
        send(16'd50,  16'd100, 16'd400, 16'd900, 16'd900);
        send(16'd200, 16'd100, 16'd400, 16'd900, 16'd900);
        send(16'd450, 16'd100, 16'd400, 16'd900, 16'd900);
        chk("skip_state", 32'(swipe_state), 32'(S_IDLE));
        send(16'd129, 16'd100, 16'd400, 16'd900, 16'd900);
        chk("edge129", 32'(swipe_state), 32'(S_Z0));
        send(16'd130, 16'd100, 16'd400, 16'd900, 16'd900);
        chk("edge130", 32'(swipe_state), 32'(S_Z1));
        send(16'd260, 16'd100, 16'd400, 16'd900, 16'd900);
        chk("edge260", 32'(swipe_state), 32'(S_Z2));
        send(16'd390, 16'd100, 16'd400, 16'd900, 16'd900);
        chk("edge390", 32'(swipe_state), 32'(S_Z3));
        send(16'd519, 16'd100, 16'd400, 16'd900, 16'd900);
        chk("edge519", 32'(swipe_state), 32'(S_Z3));
        send(16'd520, 16'd100, 16'd400, 16'd900, 16'd900);
        expect_out("edge520", 8'd0, 8'd128, 8'd128, 1'b1, S_LOCK);

        // Reset one cycle after a strobe flushes all in-flight frames.
        @(negedge vclock);
        drive(16'd300, 16'd100, 16'd100, 16'd900, 16'd900);
        @(negedge vclock);
        reset = 1'b1;
        drive(16'd300, 16'd200, 16'd100, 16'd700, 16'd700);
        @(negedge vclock);
        chk("flush_cv_0", 32'(cmd_valid), 32'd0);
        drive(16'd300, 16'd0, 16'd300, 16'd2000, 16'd2000);
        @(negedge vclock);
        reset = 1'b0;
        hands_valid = 1'b0;
        for (int i = 1; i < 5; i++) begin
            chk($sformatf("flush_cv_%0d", i), 32'(cmd_valid), 32'd0);
            @(negedge vclock);
        end
        expect_out("flush", 8'd0, 8'd128, 8'd128, 1'b0, S_IDLE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gesture_command_gen.md
Name: gesture_command_gen

Overview:
- Converts per-frame Kinect hand coordinates into the drone command bytes (hover, roll, pitch) and the armed flag (on).
- Sits directly upstream of the hand-location display and the drone command link; both consume its outputs.
- A swipe FSM in the bottom-third dead zone toggles on/off.
- A two-stage pipeline computes saturated 8-bit commands, neutral when disarmed or when hands are not usable.

Parameters:
- DEAD_Y, 342: Kinect y at or above this value is inside the dead zone (display bottom third).
- ZONE_W, 130: width of one swipe column in Kinect x. Zone boundaries are at 130, 260, 390 and 520; zone 4 is x>=520.
- HOVER_K, 191: hover scale, applied as ((DEAD_Y-1-y_avg)*HOVER_K)>>8.
- MIN_Z_DEAD_ZONE, 800: pitch neutral band, lower bound.
- MAX_Z_DEAD_ZONE, 1050: pitch neutral band, upper bound.
- TIMEOUT_FRAMES, 15: maximum valid frames allowed between swipe zone advances.

Ports:
- vclock, in, 1: 65 MHz clock; all logic on its rising edge.
- reset, in, 1: synchronous, active-high reset.
- hands_valid, in, 1: one-cycle strobe marking a new coordinate frame.
- x1, in, 16: left hand x (Kinect units).
- y1, in, 16: left hand y.
- z1, in, 16: left hand depth; 0 means untracked.
- x2, in, 16: right hand x.
- y2, in, 16: right hand y.
- z2, in, 16: right hand depth; 0 means untracked.
- hover, out, 8: throttle command.
- roll, out, 8: roll command; 128 is neutral.
- pitch, out, 8: pitch command; 128 is neutral.
- on, out, 1: armed flag.
- cmd_valid, out, 1: one-cycle strobe; hover, roll, pitch and on are updated in this cycle.

Behaviour:
- Reset values: on=0, hover=0, roll=128, pitch=128, cmd_valid=0, FSM=IDLE, timeout counter=0, both pipeline valid bits cleared.
- Reset mid-operation: frames already in the pipeline are dropped; no cmd_valid is produced for them.
- Pipeline timing:
  - hands_valid in cycle N gives cmd_valid in cycle N+2.
  - Back-to-back strobes are accepted; each strobe produces exactly one cmd_valid.
  - Inputs are sampled only in the hands_valid cycle.
- Stage 1 registers:
  - y_avg = (y1+y2)>>1, computed 17-bit.
  - dy = y1-y2, signed 17-bit.
  - z_avg = (z1+z2)>>1.
  - right-hand zone (0..4), found by comparison against k*ZONE_W.
  - flags: tracked = (z1!=0 && z2!=0); in_dz = (y2>=DEAD_Y); any_dz = (y1>=DEAD_Y || y2>=DEAD_Y).
- Swipe FSM: advances once per stage-1 valid frame. States are IDLE, Z0, Z1, Z2, Z3, LOCK.
  - If !tracked or !in_dz: go to IDLE. This has priority over every other transition.
  - IDLE: zone==0 goes to Z0.
  - Zk (k=0..3):
    - zone==k+1: advance to Z(k+1) and clear the counter. From Z3, zone==4 toggles on and goes to LOCK.
    - zone==k: stay and increment the counter. If the counter reaches TIMEOUT_FRAMES, go to IDLE.
    - any other zone: go to Z0 if zone==0, else IDLE.
  - LOCK: hold until the general rule above returns the FSM to IDLE. This prevents a re-toggle while the hand is still in the zone.
  - Skipping a zone (for example Z1 to zone 3) restarts the sequence.
- Stage 2 outputs, computed with the post-FSM value of on for the same frame:
  - Neutral case: if !on, !tracked or any_dz, output hover=0, roll=128, pitch=128.
  - hover = min(255, ((DEAD_Y-1-y_avg)*HOVER_K)>>8).
  - roll = clamp(128 + (dy>>>1), 0, 255). The shift is arithmetic.
  - pitch depends on z_avg:
    - z_avg < 800: clamp(128-((800-z_avg)>>2), 0, 255).
    - z_avg >= 1050: clamp(128+((z_avg-1050)>>2), 0, 255).
    - otherwise: 128.
  - All intermediates are at least 25 bits wide; no wrap-around is permitted before the clamp.
- Outputs hold their values between cmd_valid strobes.

Test Plan:
1. Reset: assert reset for 2 cycles with hands_valid pulsing -> on=0, hover=0, roll=128, pitch=128, no cmd_valid during reset or for the 2 cycles after release.
2. Arm swipe: z1=z2=900, y1=100, y2=400, x2=50, 200, 300, 450, 600 on consecutive frames -> on goes 0 to 1 at the 5th cmd_valid. A 6th frame with x2=600 leaves on=1 (LOCK). y2=100, then a repeat of the swipe -> on=0.
3. Commands with on=1:
   - y1=y2=100, z=900 -> hover=179, roll=128, pitch=128.
   - y1=200, y2=100, z=700 -> hover=142, roll=178, pitch=103.
4. Saturation with on=1:
   - y1=0, y2=300 -> roll=0, hover=142.
   - z1=z2=2000 -> pitch=255.
   - z1=0 -> all neutral and FSM to IDLE.
5. Timeout: swipe reaches Z2, then 16 frames at x2=300 -> FSM returns to IDLE. The following x2=450, 600 does not toggle on.
6. Pipeline: hands_valid on 3 consecutive cycles with distinct values -> 3 consecutive cmd_valid strobes at N+2..N+4 with the matching values. Reset asserted at N+1 -> no cmd_valid is produced for those frames.
